// File: rtl/cdc_arb_pkg.sv
// Shared definitions for the CDC channel arbiter and related CDC source-side blocks.
package cdc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int DEF_GAP_CYC = 4;
  localparam int DEF_TIMEOUT = 255;

  // Bits needed to index v values; never less than 1 so zero-width vectors cannot appear.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping modulo N.
module rr_pick
  import cdc_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_id,
  output logic          any
);

  always_comb begin
    int idx;
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any         = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/cdc_chan_arbiter.sv
// Shares one level-handshake CDC channel among N requesters: round-robin grant, hold until
// ack, enforced low gap so the far-side edge detector sees every transfer, optional watchdog.
module cdc_chan_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int GAP_CYC = DEF_GAP_CYC,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int IW      = clog2(N)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_vld,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_rdy,
  output logic           ch_req,
  output logic [W-1:0]   ch_data,
  input  logic           ch_ack,
  output logic           busy,
  output logic [IW-1:0]  grant_id,
  output logic           err_timeout,
  output logic [IW-1:0]  err_id
);

  localparam int WDW = clog2(TIMEOUT);
  localparam int GW  = clog2(GAP_CYC);
  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYC - 1);

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic [WDW-1:0]  r_wd, w_wd_nxt;
  logic [GW-1:0]   r_gap, w_gap_nxt;
  logic            r_ch_req, w_ch_req_nxt;
  logic [W-1:0]    r_ch_data, w_ch_data_nxt;
  logic [IW-1:0]   r_gid, w_gid_nxt;
  logic            r_err, w_err_nxt;
  logic [IW-1:0]   r_eid, w_eid_nxt;

  logic [N-1:0]    w_gnt;
  logic [IW-1:0]   w_gnt_id;
  logic            w_any;
  logic            w_expire;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req    (req_vld),
    .ptr    (r_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id),
    .any    (w_any)
  );

  assign w_expire = (TIMEOUT != 0) && (r_wd == WD_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_wd_nxt      = r_wd;
    w_gap_nxt     = r_gap;
    w_ch_req_nxt  = r_ch_req;
    w_ch_data_nxt = r_ch_data;
    w_gid_nxt     = r_gid;
    w_err_nxt     = 1'b0;
    w_eid_nxt     = r_eid;
    req_rdy       = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          req_rdy       = w_gnt;
          w_ch_data_nxt = req_data[w_gnt_id*W +: W];
          w_ch_req_nxt  = 1'b1;
          w_gid_nxt     = w_gnt_id;
          w_ptr_nxt     = (w_gnt_id == IW'(N - 1)) ? '0 : w_gnt_id + 1'b1;
          w_wd_nxt      = '0;
          w_state_nxt   = WAIT;
        end
      end
      WAIT: begin
        // Ack takes priority over a coincident watchdog expiry.
        if (ch_ack) begin
          w_ch_req_nxt = 1'b0;
          w_gap_nxt    = '0;
          w_state_nxt  = GAP;
        end else if (w_expire) begin
          w_ch_req_nxt = 1'b0;
          w_err_nxt    = 1'b1;
          w_eid_nxt    = r_gid;
          w_gap_nxt    = '0;
          w_state_nxt  = GAP;
        end else begin
          w_wd_nxt = r_wd + 1'b1;
        end
      end
      GAP: begin
        if (r_gap == GAP_LAST) w_state_nxt = IDLE;
        else                   w_gap_nxt   = r_gap + 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_wd      <= '0;
      r_gap     <= '0;
      r_ch_req  <= 1'b0;
      r_ch_data <= '0;
      r_gid     <= '0;
      r_err     <= 1'b0;
      r_eid     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_wd      <= w_wd_nxt;
      r_gap     <= w_gap_nxt;
      r_ch_req  <= w_ch_req_nxt;
      r_ch_data <= w_ch_data_nxt;
      r_gid     <= w_gid_nxt;
      r_err     <= w_err_nxt;
      r_eid     <= w_eid_nxt;
    end
  end

  assign ch_req      = r_ch_req;
  assign ch_data     = r_ch_data;
  assign busy        = (r_state != IDLE);
  assign grant_id    = r_gid;
  assign err_timeout = r_err;
  assign err_id      = r_eid;

endmodule

// File: tb/tb_cdc_chan_arbiter.sv
// Bench for cdc_chan_arbiter: transfer-level reference model checked every cycle, plus directed scenarios.
module tb_cdc_chan_arbiter;
  localparam int N = 4, W = 8, GAP_CYC = 4, TIMEOUT = 8, IW = 2;

  logic           clk, rst, ch_ack;
  logic [N-1:0]   req_vld, req_rdy;
  logic [N*W-1:0] req_data;
  logic           ch_req, busy, err_timeout;
  logic [W-1:0]   ch_data;
  logic [IW-1:0]  grant_id, err_id;

  cdc_chan_arbiter #(.N(N), .W(W), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
    .ch_req(ch_req), .ch_data(ch_data), .ch_ack(ch_ack), .busy(busy), .grant_id(grant_id),
    .err_timeout(err_timeout), .err_id(err_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Winner = first valid requester scanning upward from p, wrapping.
  function automatic int win(input logic [N-1:0] v, input int p);
    logic [2*N-1:0] dbl;
    dbl = {v, v};
    for (int off = 0; off < N; off++)
      if (dbl[p+off]) return (p + off) % N;
    return -1;
  endfunction

  // Reference model: age = cycles ch_req has been high, lo = gap cycles still owed.
  logic         m_chreq, m_err;
  logic [W-1:0] m_data;
  int           m_gid, m_eid, m_ptr, m_age, m_lo;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_chreq <= 0; m_err <= 0; m_data <= '0; m_gid <= 0; m_eid <= 0;
      m_ptr <= 0; m_age <= 0; m_lo <= 0;
    end else begin
      int w;
      w = win(req_vld, m_ptr);
      m_err <= 0;
      if (!m_chreq && m_lo == 0) begin
        if (w >= 0) begin
          m_chreq <= 1; m_data <= req_data[w*W +: W]; m_gid <= w;
          m_ptr <= (w + 1) % N; m_age <= 1;
        end
      end else if (m_chreq) begin
        if (ch_ack) begin
          m_chreq <= 0; m_lo <= GAP_CYC;
        end else if (TIMEOUT != 0 && m_age == TIMEOUT) begin
          m_chreq <= 0; m_err <= 1; m_eid <= m_gid; m_lo <= GAP_CYC;
        end else m_age <= m_age + 1;
      end else m_lo <= m_lo - 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      int w;
      logic [N-1:0] er;
      w  = win(req_vld, m_ptr);
      er = (!m_chreq && m_lo == 0 && w >= 0) ? N'(1 << w) : '0;
      chk("req_rdy", req_rdy, er);
      chk("ch_req", ch_req, m_chreq);
      if (m_chreq) chk("ch_data", ch_data, m_data);
      chk("busy", busy, (m_chreq || m_lo != 0));
      chk("grant_id", grant_id, m_gid);
      chk("err_timeout", err_timeout, m_err);
      chk("err_id", err_id, m_eid);
    end
  end

  // Transfer monitor: high-run length, grant/data at each rise, error pulse count.
  int hi_run = 0, last_hi = 0, rise_cnt = 0, err_cnt = 0;
  int gq[$];
  logic [W-1:0] dq[$];
  always @(negedge clk) begin
    if (rst) hi_run = 0;
    else begin
      if (ch_req) begin
        if (hi_run == 0) begin gq.push_back(int'(grant_id)); dq.push_back(ch_data); rise_cnt++; end
        hi_run++;
      end else if (hi_run != 0) begin
        last_hi = hi_run; hi_run = 0;
      end
      if (err_timeout) err_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_level(input logic lvl);
    for (int i = 0; i < 100; i++) begin
      if (ch_req === lvl) return;
      tick();
    end
    n_chk++; n_fail++;
    $display("FAIL wait_ch_req: level %0d not reached within 100 cycles", lvl);
  endtask

  initial begin
    int base, ec0, rc0, lo_bad;
    rst = 1; req_vld = '0; req_data = '0; ch_ack = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_rdy", req_rdy, 0); chk("rst_ch_req", ch_req, 0); chk("rst_ch_data", ch_data, 0);
    chk("rst_busy", busy, 0); chk("rst_grant_id", grant_id, 0);
    chk("rst_err_timeout", err_timeout, 0); chk("rst_err_id", err_id, 0);
    rst = 0;
    tick();

    // Single request from requester 2, ack in the 3rd high cycle.
    req_data[2*W +: W] = 8'hA5; req_vld = 4'b0100;
    @(negedge clk); chk("t1_req_rdy", req_rdy, 4'b0100);
    tick(); req_vld = '0;
    chk("t1_ch_req", ch_req, 1); chk("t1_ch_data", ch_data, 8'hA5); chk("t1_grant_id", grant_id, 2);
    tick(); tick(); ch_ack = 1; tick(); ch_ack = 0;
    lo_bad = 0;
    for (int i = 0; i < 6; i++) begin if (ch_req) lo_bad++; tick(); end
    chk("t1_low_gap", lo_bad, 0);
    chk("t1_hi_len", last_hi, 3);

    rst = 1; tick(); rst = 0; tick();

    // All four continuously valid, ack after 2 high cycles each.
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'(8'hB0 + i);
    base = gq.size(); req_vld = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_level(1);
      if (t == 4) req_vld = '0;
      tick(); ch_ack = 1; tick(); ch_ack = 0;
    end
    for (int t = 0; t < 5; t++) begin
      chk("t2_order", gq[base+t], t % N);
      chk("t2_data", dq[base+t], 8'(8'hB0 + (t % N)));
    end
    repeat (6) tick();

    // Watchdog: requester 3 never acked.
    req_data[3*W +: W] = 8'hC3; req_vld = 4'b1000; ec0 = err_cnt;
    wait_level(1); req_vld = '0;
    wait_level(0); tick();
    chk("t3_hi_len", last_hi, TIMEOUT); chk("t3_err_pulses", err_cnt - ec0, 1); chk("t3_err_id", err_id, 3);
    req_data[0 +: W] = 8'h5A; req_vld = 4'b0001;
    wait_level(1); req_vld = '0;
    chk("t3_next_gid", grant_id, 0); chk("t3_next_data", ch_data, 8'h5A);
    ch_ack = 1; tick(); ch_ack = 0;

    // Stray acks in GAP and IDLE, then ack coincident with expiry.
    tick(); ch_ack = 1; tick(); ch_ack = 0; rc0 = rise_cnt;
    repeat (6) tick();
    ch_ack = 1; tick(); ch_ack = 0; repeat (3) tick();
    chk("t4_no_spurious", rise_cnt, rc0); chk("t4_idle_busy", busy, 0);
    req_data[2*W +: W] = 8'h77; req_vld = 4'b0100; ec0 = err_cnt;
    wait_level(1); req_vld = '0;
    repeat (TIMEOUT - 1) tick();
    ch_ack = 1; tick(); ch_ack = 0; tick();
    chk("t4_coinc_no_err", err_cnt - ec0, 0); chk("t4_coinc_hi_len", last_hi, TIMEOUT);
    repeat (6) tick();

    // Asynchronous reset mid-WAIT, pointer must restart at 0.
    req_data[1*W +: W] = 8'h3C; req_vld = 4'b0010;
    wait_level(1); req_vld = '0; tick();
    #2 rst = 1; #1;
    chk("t5_ch_req", ch_req, 0); chk("t5_ch_data", ch_data, 0);
    chk("t5_busy", busy, 0); chk("t5_grant_id", grant_id, 0);
    tick(); rst = 0;
    req_data[3*W +: W] = 8'hE3; req_vld = 4'b1010;
    @(negedge clk); chk("t5_ptr_restart", req_rdy, 4'b0010);
    tick(); req_vld = '0;
    chk("t5_gid_after", grant_id, 1);
    ch_ack = 1; tick(); ch_ack = 0;
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/cdc_chan_arbiter.md
# cdc_chan_arbiter

Source-domain controller that shares one 8-bit handshake CDC channel among N requesters, all in the `clk_i` domain. It picks one requester round-robin and drives the channel's level-valid request with its data. It holds both stable until the channel returns its synchronised acknowledge pulse. It then enforces a low gap so the destination-side edge detector sees every transfer, and a watchdog releases the channel if no acknowledge arrives.

## Interface
Parameters:
- `N`, 4: number of requesters (2..8).
- `W`, 8: data width per requester.
- `GAP_CYC`, 4: minimum `clk_i` cycles `ch_req` stays low between transfers (≥1).
- `TIMEOUT`, 255: max cycles waiting for `ch_ack`; 0 disables the watchdog.

Ports:
- `clk_i` input, 1: single clock.
- `rst_i` input, 1: reset, asynchronous, active-high.
- `req_vld` input, N: per-requester valid, held until accepted.
- `req_data` input, N*W: requester i's data at bits [i*W +: W].
- `req_rdy` output, N: accept strobe; transfer happens when `req_vld[i] & req_rdy[i]`.
- `ch_req` output, 1: level request to the CDC channel (registered).
- `ch_data` output, W: data to the channel (registered, stable while `ch_req`=1).
- `ch_ack` input, 1: single-cycle acknowledge pulse, already synchronised into `clk_i`.
- `busy` output, 1: high whenever state ≠ IDLE.
- `grant_id` output, clog2(N): owner of the current or most recent transfer.
- `err_timeout` output, 1: one-cycle pulse on watchdog expiry.
- `err_id` output, clog2(N): requester that timed out, held until the next timeout.

## Operation
- Reset values: `req_rdy`=0, `ch_req`=0, `ch_data`=0, `busy`=0, `grant_id`=0, `err_timeout`=0, `err_id`=0. The round-robin pointer resets to 0 and the state resets to IDLE.
- States: IDLE, WAIT, GAP.
- IDLE
  - If any `req_vld` is set, the winner is the first set bit at or after the pointer, wrapping modulo N.
  - `req_rdy` is one-hot for the winner, combinational in this cycle only; `req_rdy` is 0 in all other states.
  - On acceptance: `ch_data` <= winner's data, `ch_req` <= 1, `grant_id` <= winner, pointer <= winner+1 mod N. The next state is WAIT.
- WAIT
  - `ch_req` and `ch_data` are held.
  - The watchdog counter increments each cycle from 0.
  - On `ch_ack`: `ch_req` <= 0 and the next state is GAP.
  - If the counter reaches TIMEOUT−1 without `ch_ack` (TIMEOUT≠0): `ch_req` <= 0, `err_timeout` pulses, `err_id` <= `grant_id`, and the next state is GAP.
- GAP
  - The gap counter counts GAP_CYC cycles with `ch_req`=0, then the state returns to IDLE.
- `ch_ack` received in IDLE or GAP is ignored. It is not counted and does not affect any output.
- `ch_ack` and watchdog expiry in the same cycle: the ack wins, and no error is raised.
- A requester dropping `req_vld` before acceptance is legal. A requester dropping `req_vld` after acceptance has no effect.
- Asserting `rst_i` mid-transfer immediately forces the reset values. The channel sees `ch_req` fall and must recover on its own reset.

## Timing
- `req_vld` seen in IDLE at cycle k: `req_rdy` is high in cycle k, and `ch_req`=1 with valid `ch_data` from cycle k+1.
- `ch_ack` at cycle m in WAIT: `ch_req`=0 from m+1. The earliest next acceptance is m+1+GAP_CYC, and the next `ch_req` rises at m+2+GAP_CYC.
- With a watchdog expiry, `ch_req` stays high for exactly TIMEOUT cycles.
- Fairness: with all N requesters continuously valid, each is granted once every N transfers.

## Structure
- A shared package/include `cdc_arb_pkg` holds:
  - the state encoding (IDLE=2'd0, WAIT=2'd1, GAP=2'd2);
  - the clog2 helper;
  - the default GAP_CYC and TIMEOUT constants, reused by other CDC blocks.
- One sub-module, `rr_pick`: combinational round-robin selector. Inputs are `req[N]` and `ptr`; outputs are `gnt` (one-hot), `gnt_id` and `any`.
- All counters and the FSM live in the top module.

## Test plan
- Single request: N=4, `req_vld`=4'b0100 with data 8'hA5, and ack returned 3 cycles after `ch_req` rises. Required: `req_rdy`=4'b0100 for 1 cycle; `ch_req`=1 with `ch_data`=8'hA5 for 3 cycles; `grant_id`=2; then `ch_req`=0 for ≥4 cycles.
- All four valid continuously, ack after 2 cycles each time. Required: grant order 0,1,2,3,0, and each `ch_data` matches its requester's data.
- No ack, TIMEOUT=8, requester 3 granted. Required: `ch_req` high exactly 8 cycles, one `err_timeout` pulse, `err_id`=3, then GAP, then the next grant proceeds normally.
- `ch_ack` pulsed in IDLE and in GAP. Required: no state change and no spurious transfer; ack coincident with watchdog expiry gives `err_timeout`=0.
- `rst_i` asserted mid-WAIT. Required: `ch_req`, `ch_data`, `busy` and `grant_id` go to 0 asynchronously, and after release the pointer restarts at 0.
